onehot_decoder_pipe: RTL and testbench
======================================

Name: onehot_decoder_pipe

Overview:
Parametrised, registered binary-to-one-hot select decoder. Successor to the fixed 8-to-256 combinational decoder: configurable address width and output count, a one-entry pipeline stage with valid/ready handshake, out-of-range detection and a saturating error counter. Sits between bus/peripheral address logic and per-slot enable fabric in the SoC components tree.

Parameters:
ADDR_WIDTH, 8, width of addr_i (1..10)
NUM_SEL, 256, number of select lines; legal range 1..2**ADDR_WIDTH
ERR_CNT_WIDTH, 8, width of saturating error counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
addr_valid_i  input  1  address request valid
addr_ready_o  output  1  block can accept a request this cycle
addr_i  input  ADDR_WIDTH  binary address
sel_valid_o  output  1  select_o/err_o hold a decoded result
sel_ack_i  input  1  consumer accepts the current result
select_o  output  NUM_SEL  one-hot select (all zero when invalid or error)
err_o  output  1  current result is out-of-range (qualified by sel_valid_o)
err_cnt_o  output  ERR_CNT_WIDTH  count of out-of-range requests, saturating
err_clr_i  input  1  synchronous clear of err_cnt_o

Behaviour:
- Reset (async, rst_n=0): sel_valid_o=0, select_o=0, err_o=0, err_cnt_o=0. Release is glitch-free; first accept is possible on the first clk edge after release.
- addr_ready_o = !sel_valid_o || sel_ack_i (combinational). This is a one-entry pipeline, with no skid buffer.
- Accept = addr_valid_i && addr_ready_o. On accept, at the next edge:
  - sel_valid_o=1.
  - If addr_i < NUM_SEL: select_o = 1 << addr_i, err_o=0.
  - Otherwise: select_o=0, err_o=1.
- Latency: 1 cycle from accept to sel_valid_o. Throughput is 1 per cycle while sel_ack_i=1.
- Holding: while sel_valid_o=1 && sel_ack_i=0, select_o/err_o/sel_valid_o stay stable and addr_i is ignored.
- sel_ack_i=1 with no new accept: sel_valid_o->0 and select_o->0 at the next edge. sel_ack_i while sel_valid_o=0 has no effect.
- Simultaneous ack + accept: the new result replaces the old one at the same edge. sel_valid_o stays 1 with no bubble.
- Invariant: select_o is one-hot or zero. It is never nonzero while sel_valid_o=0 or err_o=1.
- Error counter: increments by 1 on each accepted out-of-range request and saturates at 2**ERR_CNT_WIDTH-1.
  - err_clr_i clears it at the next edge.
  - err_clr_i and an increment in the same cycle: clear wins, and the result is 0.
- NUM_SEL = 2**ADDR_WIDTH: out-of-range is impossible, and err_o and err_cnt_o stay 0.
- Reset mid-transaction: any pending result is dropped and no ack is required.

Optional Feature:
Macro DECODER_PARITY_EN.
- Defined: adds input port addr_par_i (1 bit), giving even parity over {addr_par_i, addr_i}. An accepted request with a parity mismatch is treated as an error: select_o=0, err_o=1, and err_cnt_o increments, even if addr_i is in range.
- Undefined: the port is absent and there is no parity check. Behaviour is otherwise identical.

Test Plan:
1. Reset, then addr_i=8'd5, addr_valid_i=1, sel_ack_i=1 for one cycle -> next cycle sel_valid_o=1, select_o=bit 5 only, err_o=0; the following cycle sel_valid_o=0, select_o=0.
2. Back-to-back addresses 0,1,255 with sel_ack_i held 1 -> select_o equals bit0, bit1, bit255 on three consecutive cycles; addr_ready_o stays 1 throughout.
3. Backpressure: accept addr 7, hold sel_ack_i=0 for 4 cycles while driving addr 9 valid -> addr_ready_o=0 and select_o=bit7 stable; after ack, bit9 appears one cycle later.
4. NUM_SEL=200: send addr 200 and 250 -> err_o=1, select_o=0 each time, err_cnt_o=2. Assert err_clr_i together with a third bad request -> err_cnt_o=0.
5. ERR_CNT_WIDTH=2: send 5 out-of-range requests -> err_cnt_o saturates at 3.
6. Assert rst_n low while sel_valid_o=1 -> all outputs read 0 immediately (asynchronously). With DECODER_PARITY_EN defined: addr 3 with addr_par_i=1 -> err_o=1, select_o=0.

Source files
------------

// File: rtl/onehot_decoder_pipe.sv
// Registered binary-to-one-hot decoder with a one-entry valid/ready stage,
// out-of-range detection and a saturating error counter. Optional parity check: DECODER_PARITY_EN.
module onehot_decoder_pipe #(
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned NUM_SEL       = 256,
  parameter int unsigned ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     addr_valid_i,
  output logic                     addr_ready_o,
  input  logic [ADDR_WIDTH-1:0]    addr_i,
`ifdef DECODER_PARITY_EN
  input  logic                     addr_par_i,
`endif
  output logic                     sel_valid_o,
  input  logic                     sel_ack_i,
  output logic [NUM_SEL-1:0]       select_o,
  output logic                     err_o,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt_o,
  input  logic                     err_clr_i
);

  // With a fully populated address space no address can be out of range.
  localparam bit FullRange = (NUM_SEL == (32'd1 << ADDR_WIDTH));
  localparam logic [NUM_SEL-1:0] SelOne = 1;

  logic                     valid_q, valid_d;
  logic [NUM_SEL-1:0]       sel_q, sel_d;
  logic                     err_q, err_d;
  logic [ERR_CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [31:0] addr_ext;
  logic        in_range;
  logic        par_ok;
  logic        bad;
  logic        accept;

  assign addr_ext     = 32'(addr_i);
  assign in_range     = FullRange ? 1'b1 : (addr_ext < NUM_SEL);
`ifdef DECODER_PARITY_EN
  // Even parity: the XOR over {addr_par_i, addr_i} must be zero.
  assign par_ok       = ~(^{addr_par_i, addr_i});
`else
  assign par_ok       = 1'b1;
`endif
  assign bad          = !in_range || !par_ok;
  assign addr_ready_o = !valid_q || sel_ack_i;
  assign accept       = addr_valid_i && addr_ready_o;

  always_comb begin
    valid_d = valid_q;
    sel_d   = sel_q;
    err_d   = err_q;
    if (accept) begin
      valid_d = 1'b1;
      err_d   = bad;
      sel_d   = bad ? '0 : (SelOne << addr_i);
    end else if (sel_ack_i) begin
      valid_d = 1'b0;
      sel_d   = '0;
      err_d   = 1'b0;
    end
  end

  // Clear has priority over a same-cycle increment.
  always_comb begin
    cnt_d = cnt_q;
    if (err_clr_i) begin
      cnt_d = '0;
    end else if (accept && bad && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sel_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sel_valid_o = valid_q;
  assign select_o    = sel_q;
  assign err_o       = err_q;
  assign err_cnt_o   = cnt_q;

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// Bench for onehot_decoder_pipe: a full-range instance (256 selects) and a
// partial one (200 selects, 2-bit counter), both checked against a cycle model.
module tb_onehot_decoder_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         a_vld, a_ack, a_clr, a_rdy, a_sv, a_err;
  logic [7:0]   a_addr;
  logic [255:0] a_sel;
  logic [7:0]   a_cnt;
  logic         b_vld, b_ack, b_clr, b_rdy, b_sv, b_err;
  logic [7:0]   b_addr;
  logic [199:0] b_sel;
  logic [1:0]   b_cnt;
`ifdef DECODER_PARITY_EN
  logic a_pflip, b_pflip, a_par, b_par;
  assign a_par = (^a_addr) ^ a_pflip;
  assign b_par = (^b_addr) ^ b_pflip;
`endif

  onehot_decoder_pipe #(.ADDR_WIDTH(8), .NUM_SEL(256), .ERR_CNT_WIDTH(8)) u_full (
    .clk(clk), .rst_n(rst_n), .addr_valid_i(a_vld), .addr_ready_o(a_rdy), .addr_i(a_addr),
`ifdef DECODER_PARITY_EN
    .addr_par_i(a_par),
`endif
    .sel_valid_o(a_sv), .sel_ack_i(a_ack), .select_o(a_sel), .err_o(a_err),
    .err_cnt_o(a_cnt), .err_clr_i(a_clr)
  );

  onehot_decoder_pipe #(.ADDR_WIDTH(8), .NUM_SEL(200), .ERR_CNT_WIDTH(2)) u_part (
    .clk(clk), .rst_n(rst_n), .addr_valid_i(b_vld), .addr_ready_o(b_rdy), .addr_i(b_addr),
`ifdef DECODER_PARITY_EN
    .addr_par_i(b_par),
`endif
    .sel_valid_o(b_sv), .sel_ack_i(b_ack), .select_o(b_sel), .err_o(b_err),
    .err_cnt_o(b_cnt), .err_clr_i(b_clr)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: idx = -1 marks an error result.
  bit ma_valid, mb_valid;
  int ma_idx, mb_idx, ma_cnt, mb_cnt;

  function automatic logic [255:0] exp_a_sel();
    logic [255:0] v = '0;
    if (ma_valid && ma_idx >= 0) v[ma_idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [199:0] exp_b_sel();
    logic [199:0] v = '0;
    if (mb_valid && mb_idx >= 0) v[mb_idx] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    ma_valid = 0; mb_valid = 0; ma_idx = 0; mb_idx = 0; ma_cnt = 0; mb_cnt = 0;
  endtask

  task automatic idle_inputs();
    a_vld = 0; a_ack = 0; a_clr = 0; a_addr = '0;
    b_vld = 0; b_ack = 0; b_clr = 0; b_addr = '0;
`ifdef DECODER_PARITY_EN
    a_pflip = 0; b_pflip = 0;
`endif
  endtask

  // Advance one clock, updating the reference from the inputs seen at the edge.
  task automatic tick();
    bit acc, bad;
    @(posedge clk);
    acc = a_vld && (!ma_valid || a_ack);
    bad = 0;
`ifdef DECODER_PARITY_EN
    bad = a_pflip;
`endif
    if (acc) begin
      ma_valid = 1; ma_idx = bad ? -1 : int'(a_addr);
      if (bad && ma_cnt < 255) ma_cnt++;
    end else if (a_ack) ma_valid = 0;
    if (a_clr) ma_cnt = 0;

    acc = b_vld && (!mb_valid || b_ack);
    bad = (b_addr >= 200);
`ifdef DECODER_PARITY_EN
    bad = bad || b_pflip;
`endif
    if (acc) begin
      mb_valid = 1; mb_idx = bad ? -1 : int'(b_addr);
      if (bad && mb_cnt < 3) mb_cnt++;
    end else if (b_ack) mb_valid = 0;
    if (b_clr) mb_cnt = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    checks++;
    if (a_sv !== 1'b0 || a_sel !== '0 || a_err !== 1'b0 || a_cnt !== '0 || a_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_a got sv=%b sel=%h err=%b cnt=%0d rdy=%b exp 0/0/0/0/1",
               a_sv, a_sel, a_err, a_cnt, a_rdy);
    end
    checks++;
    if (b_sv !== 1'b0 || b_sel !== '0 || b_err !== 1'b0 || b_cnt !== '0) begin
      errors++;
      $display("FAIL reset_b got sv=%b sel=%h err=%b cnt=%0d exp all 0", b_sv, b_sel, b_err, b_cnt);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    a_vld = 1; a_ack = 1; a_addr = 8'd5;
    tick();
    a_vld = 0;
    checks++;
    if (a_sv !== 1'b1 || a_sel !== (256'd1 << 5) || a_err !== 1'b0) begin
      errors++;
      $display("FAIL single_hit got sv=%b sel=%h err=%b exp sv=1 bit5 err=0", a_sv, a_sel, a_err);
    end
    tick();
    a_ack = 0;
    checks++;
    if (a_sv !== 1'b0 || a_sel !== '0) begin
      errors++;
      $display("FAIL single_drain got sv=%b sel=%h exp 0/0", a_sv, a_sel);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [3] = '{8'd0, 8'd1, 8'd255};
    a_ack = 1;
    for (int i = 0; i < 3; i++) begin
      a_vld = 1; a_addr = seq[i];
      #1;
      checks++;
      if (a_rdy !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready[%0d] got %b exp 1", i, a_rdy);
      end
      tick();
      checks++;
      if (a_sv !== 1'b1 || a_sel !== (256'd1 << seq[i])) begin
        errors++;
        $display("FAIL b2b_sel[%0d] got sv=%b sel=%h exp bit %0d", i, a_sv, a_sel, seq[i]);
      end
    end
    a_vld = 0;
    tick();
    a_ack = 0;
  endtask

  task automatic test_backpressure();
    a_vld = 1; a_ack = 1; a_addr = 8'd7;
    tick();
    a_ack = 0; a_addr = 8'd9;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (a_rdy !== 1'b0) begin
        errors++;
        $display("FAIL bp_ready[%0d] got %b exp 0", i, a_rdy);
      end
      tick();
      checks++;
      if (a_sv !== 1'b1 || a_sel !== (256'd1 << 7)) begin
        errors++;
        $display("FAIL bp_hold[%0d] got sv=%b sel=%h exp bit 7", i, a_sv, a_sel);
      end
    end
    a_ack = 1;
    tick();
    a_vld = 0;
    checks++;
    if (a_sv !== 1'b1 || a_sel !== (256'd1 << 9)) begin
      errors++;
      $display("FAIL bp_release got sv=%b sel=%h exp bit 9", a_sv, a_sel);
    end
    tick();
    a_ack = 0;
  endtask

  task automatic test_out_of_range();
    logic [7:0] bad [2] = '{8'd200, 8'd250};
    b_ack = 1;
    for (int i = 0; i < 2; i++) begin
      b_vld = 1; b_addr = bad[i];
      tick();
      checks++;
      if (b_sv !== 1'b1 || b_err !== 1'b1 || b_sel !== '0) begin
        errors++;
        $display("FAIL oor[%0d] got sv=%b err=%b sel=%h exp 1/1/0", i, b_sv, b_err, b_sel);
      end
    end
    checks++;
    if (b_cnt !== 2'd2) begin
      errors++;
      $display("FAIL oor_count got %0d exp 2", b_cnt);
    end
    b_addr = 8'd199;
    tick();
    checks++;
    if (b_err !== 1'b0 || b_sel !== (200'd1 << 199) || b_cnt !== 2'd2) begin
      errors++;
      $display("FAIL edge_199 got err=%b sel=%h cnt=%0d exp 0/bit199/2", b_err, b_sel, b_cnt);
    end
    b_addr = 8'd222; b_clr = 1;
    tick();
    b_clr = 0;
    checks++;
    if (b_cnt !== 2'd0 || b_err !== 1'b1) begin
      errors++;
      $display("FAIL clr_wins got cnt=%0d err=%b exp 0/1", b_cnt, b_err);
    end
    b_vld = 0;
    tick();
    b_ack = 0;
  endtask

  task automatic test_saturate();
    b_ack = 1; b_vld = 1;
    for (int i = 0; i < 5; i++) begin
      b_addr = 8'(200 + i * 11);
      tick();
    end
    b_vld = 0;
    checks++;
    if (b_cnt !== 2'd3) begin
      errors++;
      $display("FAIL saturate got %0d exp 3", b_cnt);
    end
    tick();
    b_ack = 0;
  endtask

`ifdef DECODER_PARITY_EN
  task automatic test_parity();
    a_vld = 1; a_ack = 1; a_addr = 8'd3; a_pflip = 1;
    tick();
    a_vld = 0; a_pflip = 0;
    checks++;
    if (a_err !== 1'b1 || a_sel !== '0 || a_cnt !== 8'(ma_cnt)) begin
      errors++;
      $display("FAIL parity got err=%b sel=%h cnt=%0d exp 1/0/%0d", a_err, a_sel, a_cnt, ma_cnt);
    end
    tick();
    a_ack = 0;
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      a_vld = 1'($urandom_range(0, 3) != 0);
      a_ack = 1'($urandom_range(0, 2) != 0);
      a_clr = 1'($urandom_range(0, 19) == 0);
      a_addr = 8'($urandom_range(0, 255));
      b_vld = 1'($urandom_range(0, 3) != 0);
      b_ack = 1'($urandom_range(0, 2) != 0);
      b_clr = 1'($urandom_range(0, 24) == 0);
      b_addr = 8'($urandom_range(0, 255));
      #1;
      checks++;
      if (a_rdy !== (!ma_valid || a_ack) || b_rdy !== (!mb_valid || b_ack)) begin
        errors++;
        $display("FAIL rnd_ready[%0d] got a=%b b=%b exp a=%b b=%b", c, a_rdy, b_rdy,
                 !ma_valid || a_ack, !mb_valid || b_ack);
      end
      tick();
      checks++;
      if (a_sv !== ma_valid || a_sel !== exp_a_sel() || a_err !== (ma_valid && ma_idx < 0) ||
          a_cnt !== 8'(ma_cnt)) begin
        errors++;
        $display("FAIL rnd_a[%0d] got sv=%b sel=%h err=%b cnt=%0d exp sv=%b idx=%0d cnt=%0d",
                 c, a_sv, a_sel, a_err, a_cnt, ma_valid, ma_idx, ma_cnt);
      end
      checks++;
      if (b_sv !== mb_valid || b_sel !== exp_b_sel() || b_err !== (mb_valid && mb_idx < 0) ||
          b_cnt !== 2'(mb_cnt)) begin
        errors++;
        $display("FAIL rnd_b[%0d] got sv=%b sel=%h err=%b cnt=%0d exp sv=%b idx=%0d cnt=%0d",
                 c, b_sv, b_sel, b_err, b_cnt, mb_valid, mb_idx, mb_cnt);
      end
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    a_vld = 1; a_ack = 1; a_addr = 8'd42;
    b_vld = 1; b_ack = 1; b_addr = 8'd230;
    tick();
    idle_inputs();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (a_sv !== 1'b0 || a_sel !== '0 || a_err !== 1'b0 || a_cnt !== '0) begin
      errors++;
      $display("FAIL async_rst_a got sv=%b sel=%h err=%b cnt=%0d exp 0", a_sv, a_sel, a_err, a_cnt);
    end
    checks++;
    if (b_sv !== 1'b0 || b_err !== 1'b0 || b_cnt !== '0) begin
      errors++;
      $display("FAIL async_rst_b got sv=%b err=%b cnt=%0d exp 0", b_sv, b_err, b_cnt);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_out_of_range();
    test_saturate();
`ifdef DECODER_PARITY_EN
    test_parity();
`endif
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
